// File: rtl/ahb_lite_fir_n.sv
// AHB-Lite slave wrapping a serial-MAC FIR filter with a NUM_TAPS-deep sample delay line.
// Coefficients are unsigned Q1.15; each accepted sample write starts one NUM_TAPS-cycle MAC pass.
module ahb_lite_fir_n #(
  parameter int unsigned NUM_TAPS = 4,
  parameter int unsigned ACC_W    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [4:0]  haddr,
  input  logic        hsize,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [15:0] hwdata,
  output logic [15:0] hrdata,
  output logic        hresp
);

  localparam logic [5:0] EndAddr = 6'(8 + 2 * NUM_TAPS);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e state_q, state_d;

  logic             dp_valid_q, dp_valid_d;
  logic             dp_write_q, dp_write_d;
  logic             dp_size_q, dp_size_d;
  logic [4:0]       dp_addr_q, dp_addr_d;
  logic [15:0]      coef_q [NUM_TAPS];
  logic [15:0]      coef_d [NUM_TAPS];
  logic [15:0]      x_q [NUM_TAPS];
  logic [15:0]      x_d [NUM_TAPS];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             newres_q, newres_d;

  logic        busy, mac_en, done_en;
  logic [3:0]  word_idx, coef_idx;
  logic        addr_low, out_of_range, err, wr_ok, rd_ok;
  logic        sample_wr, flush, coef_wr, last_tap, acc_sat;
  logic [15:0] sample_val, ctrl_val, tap_x, tap_c, rd_data;
  logic [31:0] prod;
  logic        unused_bits;

  // Byte writes replace only the lane picked by the address LSB.
  function automatic logic [15:0] merge(input logic [15:0] old, input logic sz,
                                        input logic lane, input logic [15:0] wd);
    if (sz) return wd;
    else if (lane) return {wd[15:8], old[7:0]};
    else return {old[15:8], wd[7:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample_wr) state_d = StMac;
      StMac:   if (last_tap) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    mac_en  = (state_q == StMac);
    done_en = (state_q == StDone);
  end

  assign word_idx     = dp_addr_q[4:1];
  assign coef_idx     = word_idx - 4'd4;
  assign addr_low     = dp_addr_q < 5'd4;
  assign out_of_range = {1'b0, dp_addr_q} >= EndAddr;
  assign err          = dp_valid_q & ((dp_write_q & addr_low) | out_of_range |
                                      (dp_write_q & busy & ~addr_low));
  assign wr_ok        = dp_valid_q & dp_write_q & ~err;
  assign rd_ok        = dp_valid_q & ~dp_write_q & ~err;
  assign sample_val   = merge(16'h0000, dp_size_q, dp_addr_q[0], hwdata);
  assign ctrl_val     = merge(16'h0000, dp_size_q, dp_addr_q[0], hwdata);
  assign sample_wr    = wr_ok & (word_idx == 4'd2);
  assign flush        = wr_ok & (word_idx == 4'd3) & ctrl_val[0];
  assign coef_wr      = wr_ok & (word_idx >= 4'd4);

  always_comb begin
    tap_x = '0;
    tap_c = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      if (cnt_q == 4'(i)) begin
        tap_x = x_q[i];
        tap_c = coef_q[i];
      end
    end
  end

  assign prod        = 32'(tap_x) * 32'(tap_c);
  assign last_tap    = (cnt_q == 4'(NUM_TAPS - 1));
  assign acc_sat     = acc_q > ACC_W'(16'hFFFF);
  assign unused_bits = ^{htrans[0], prod[14:0], ctrl_val[15:1]};

  always_comb begin
    dp_valid_d = hsel & htrans[1];
    dp_addr_d  = dp_addr_q;
    dp_write_d = dp_write_q;
    dp_size_d  = dp_size_q;
    if (dp_valid_d) begin
      dp_addr_d  = haddr;
      dp_write_d = hwrite;
      dp_size_d  = hsize;
    end

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (sample_wr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (mac_en) begin
      acc_d = acc_q + ACC_W'(prod[31:15]);
      cnt_d = cnt_q + 4'd1;
    end

    result_d = result_q;
    if (done_en) result_d = acc_sat ? 16'hFFFF : acc_q[15:0];

    // Sticky flags: a set event in the same cycle beats a clearing read.
    ovf_d = ovf_q;
    if (rd_ok && word_idx == 4'd0) ovf_d = 1'b0;
    if (done_en && acc_sat) ovf_d = 1'b1;

    newres_d = newres_q;
    if ((rd_ok && word_idx == 4'd1) || sample_wr) newres_d = 1'b0;
    if (done_en) newres_d = 1'b1;

    for (int i = 0; i < NUM_TAPS; i++) begin
      x_d[i]    = x_q[i];
      coef_d[i] = coef_q[i];
      if (coef_wr && coef_idx == 4'(i)) coef_d[i] = merge(coef_q[i], dp_size_q, dp_addr_q[0], hwdata);
    end
    if (flush) begin
      for (int i = 0; i < NUM_TAPS; i++) x_d[i] = '0;
    end else if (sample_wr) begin
      x_d[0] = sample_val;
      for (int i = 1; i < NUM_TAPS; i++) x_d[i] = x_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_write_q <= 1'b0;
      dp_size_q  <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      newres_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_q[i] <= '0;
        x_q[i]    <= '0;
      end
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_addr_q  <= dp_addr_d;
      dp_write_q <= dp_write_d;
      dp_size_q  <= dp_size_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      newres_q   <= newres_d;
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef_q[i] <= coef_d[i];
        x_q[i]    <= x_d[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (word_idx)
      4'd0: rd_data = {13'b0, newres_q, ovf_q, busy};
      4'd1: rd_data = result_q;
      default: begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          if (word_idx >= 4'd4 && coef_idx == 4'(i)) rd_data = coef_q[i];
        end
      end
    endcase
  end

  assign hrdata = (rd_ok & ~rst) ? rd_data : 16'h0000;
  assign hresp  = err & ~rst;

endmodule

// File: tb/tb_ahb_lite_fir_n.sv
// Bench for ahb_lite_fir_n: register-map vector table, directed filter scenarios and random
// samples/coefficients checked against an arithmetic FIR model.
module tb_ahb_lite_fir_n;

  localparam int unsigned NT = 4;

  logic        tb_clk = 1'b0;
  logic        rst, hsel, hsize, hwrite, hresp;
  logic [4:0]  haddr;
  logic [1:0]  htrans;
  logic [15:0] hwdata, hrdata;

  int checks   = 0;
  int failures = 0;

  longint unsigned mcoef [NT];
  longint unsigned mx [NT];

  typedef struct {
    logic [4:0]  addr;
    logic        wr;
    logic        sz;
    logic [15:0] wdata;
    logic        exp_resp;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [21];

  always #5 tb_clk = ~tb_clk;

  ahb_lite_fir_n #(.NUM_TAPS(NT), .ACC_W(24)) dut (
    .clk    (tb_clk),
    .rst    (rst),
    .hsel   (hsel),
    .haddr  (haddr),
    .hsize  (hsize),
    .htrans (htrans),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hresp  (hresp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned model_sum();
    longint unsigned s = 0;
    for (int i = 0; i < NT; i++) s += (mx[i] * mcoef[i]) >> 15;
    return s;
  endfunction

  task automatic model_sample(input logic [15:0] v);
    for (int i = NT - 1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      mx[i] = 0;
      mcoef[i] = 0;
    end
  endtask

  // One bus cycle: sample the current data phase, then drive the next address phase.
  task automatic step(input logic sel, input logic [4:0] a, input logic w, input logic s,
                      input logic [15:0] wd, output logic [15:0] rd, output logic rsp);
    rd = hrdata;
    rsp = hresp;
    hsel = sel;
    haddr = a;
    hwrite = w;
    hsize = s;
    htrans = sel ? 2'b10 : 2'b00;
    hwdata = wd;
    @(posedge tb_clk);
    #1;
  endtask

  task automatic xfer(input logic [4:0] a, input logic w, input logic s, input logic [15:0] wd,
                      output logic [15:0] rd, output logic rsp);
    logic [15:0] d0;
    logic        r0;
    step(1'b1, a, w, s, 16'h0, d0, r0);
    step(1'b0, 5'h0, 1'b0, 1'b0, wd, rd, rsp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hsel = 1'b0;
    htrans = 2'b00;
    haddr = '0;
    hwrite = 1'b0;
    hsize = 1'b0;
    hwdata = '0;
    repeat (2) @(posedge tb_clk);
    #1;
    check("rst_hrdata", hrdata, 0);
    check("rst_hresp", hresp, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_coef(input int idx, input logic [15:0] v);
    logic [15:0] rd;
    logic        rsp;
    xfer(5'(8 + 2 * idx), 1'b1, 1'b1, v, rd, rsp);
    check("coef_wr_resp", rsp, 0);
    mcoef[idx] = v;
  endtask

  // Sample write followed by back-to-back status polls until busy drops.
  task automatic do_sample(input logic [15:0] v, output int nbusy, output logic [15:0] st,
                           output logic wresp);
    logic [15:0] rd;
    logic        rsp;
    int          k;
    step(1'b1, 5'h04, 1'b1, 1'b1, 16'h0, rd, rsp);
    step(1'b1, 5'h00, 1'b0, 1'b1, v, rd, rsp);
    wresp = rsp;
    nbusy = 0;
    k = 0;
    do begin
      step(1'b1, 5'h00, 1'b0, 1'b1, 16'h0, rd, rsp);
      k++;
      if (rd[0]) nbusy++;
    end while (rd[0] && k < 20);
    st = rd;
    step(1'b0, 5'h00, 1'b0, 1'b0, 16'h0, rd, rsp);
  endtask

  task automatic run_sample(input logic [15:0] v, output logic [15:0] res);
    longint unsigned s;
    logic [15:0]     exp_res, st;
    logic            exp_ovf, wr, rsp;
    int              nb;
    model_sample(v);
    s = model_sum();
    exp_ovf = (s > 65535);
    exp_res = exp_ovf ? 16'hFFFF : s[15:0];
    do_sample(v, nb, st, wr);
    check("sample_resp", wr, 0);
    check("busy_cycles", nb, NT + 1);
    check("status_done", st, {13'b0, 1'b1, exp_ovf, 1'b0});
    xfer(5'h02, 1'b0, 1'b1, 16'h0, res, rsp);
    check("result", res, exp_res);
    check("result_resp", rsp, 0);
  endtask

  task automatic wait_idle();
    logic [15:0] rd;
    logic        rsp;
    int          k = 0;
    do begin
      xfer(5'h00, 1'b0, 1'b1, 16'h0, rd, rsp);
      k++;
    end while (rd[0] && k < 20);
    check("idle_reached", rd[0], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, res;
    logic        rsp;
    logic [15:0] c4 [NT];

    vecs[0]  = '{5'h08, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{5'h08, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1234};
    vecs[2]  = '{5'h09, 1'b1, 1'b0, 16'hAB00, 1'b0, 16'h0000};
    vecs[3]  = '{5'h08, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hAB34};
    vecs[4]  = '{5'h08, 1'b1, 1'b0, 16'h00CD, 1'b0, 16'h0000};
    vecs[5]  = '{5'h08, 1'b0, 1'b1, 16'h0000, 1'b0, 16'hABCD};
    vecs[6]  = '{5'h02, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0000};
    vecs[7]  = '{5'h00, 1'b1, 1'b1, 16'h0007, 1'b1, 16'h0000};
    vecs[8]  = '{5'h01, 1'b1, 1'b0, 16'h0500, 1'b1, 16'h0000};
    vecs[9]  = '{5'h10, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{5'h10, 1'b1, 1'b1, 16'h4444, 1'b1, 16'h0000};
    vecs[11] = '{5'h1F, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000};
    vecs[12] = '{5'h04, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[13] = '{5'h06, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[14] = '{5'h0E, 1'b1, 1'b1, 16'h5555, 1'b0, 16'h0000};
    vecs[15] = '{5'h0F, 1'b1, 1'b0, 16'h1200, 1'b0, 16'h0000};
    vecs[16] = '{5'h0E, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1255};
    vecs[17] = '{5'h0A, 1'b1, 1'b1, 16'h7777, 1'b0, 16'h0000};
    vecs[18] = '{5'h0A, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h7777};
    vecs[19] = '{5'h02, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[20] = '{5'h00, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    c4[0] = 16'h4000;
    c4[1] = 16'h8000;
    c4[2] = 16'h8000;
    c4[3] = 16'h4000;

    // Reset state
    do_reset();
    xfer(5'h00, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("reset_status", rd, 0);
    check("reset_status_resp", rsp, 0);
    xfer(5'h02, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("reset_result", rd, 0);
    xfer(5'h08, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("reset_coef0", rd, 0);
    check("reset_coef0_resp", rsp, 0);

    // Register map vectors
    for (int i = 0; i < 21; i++) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].sz, vecs[i].wdata, rd, rsp);
      check($sformatf("vec%0d_resp", i), rsp, vecs[i].exp_resp);
      if (!vecs[i].wr && !vecs[i].exp_resp) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Four equal samples through a symmetric 4-tap filter
    do_reset();
    for (int i = 0; i < NT; i++) set_coef(i, c4[i]);
    run_sample(16'd100, res);
    check("fir_res0", res, 50);
    run_sample(16'd100, res);
    check("fir_res1", res, 150);
    run_sample(16'd100, res);
    check("fir_res2", res, 250);
    run_sample(16'd100, res);
    check("fir_res3", res, 300);

    // Saturation and sticky overflow
    do_reset();
    for (int i = 0; i < NT; i++) set_coef(i, 16'h8000);
    run_sample(16'hFFFF, res);
    check("sat_res0", res, 16'hFFFF);
    run_sample(16'hFFFF, res);
    check("sat_res1", res, 16'hFFFF);
    xfer(5'h00, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("ovf_and_new_cleared", rd, 0);

    // Sample write while busy is rejected
    do_reset();
    for (int i = 0; i < NT; i++) set_coef(i, 16'h8000);
    step(1'b1, 5'h04, 1'b1, 1'b1, 16'h0, rd, rsp);
    step(1'b1, 5'h04, 1'b1, 1'b1, 16'd1000, rd, rsp);
    check("b2b_first_resp", rsp, 0);
    step(1'b0, 5'h00, 1'b0, 1'b0, 16'd2000, rd, rsp);
    check("b2b_second_resp", rsp, 1);
    model_sample(16'd1000);
    wait_idle();
    xfer(5'h02, 1'b0, 1'b1, 16'h0, res, rsp);
    check("b2b_result", res, 1000);
    run_sample(16'd10, res);
    check("b2b_next_result", res, 1010);

    // Flush in idle clears only the delay line
    do_reset();
    for (int i = 0; i < NT; i++) set_coef(i, c4[i]);
    for (int i = 0; i < 3; i++) run_sample(16'd100, res);
    xfer(5'h06, 1'b1, 1'b1, 16'h0001, rd, rsp);
    check("flush_resp", rsp, 0);
    for (int i = 0; i < NT; i++) mx[i] = 0;
    xfer(5'h02, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("flush_keeps_result", rd, 250);
    xfer(5'h0A, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("flush_keeps_coef1", rd, 16'h8000);
    run_sample(16'd100, res);
    check("flush_result", res, 50);

    // Reset during MAC aborts with no result and masks an in-flight read
    do_reset();
    set_coef(0, 16'h8000);
    step(1'b1, 5'h04, 1'b1, 1'b1, 16'h0, rd, rsp);
    step(1'b0, 5'h00, 1'b0, 1'b0, 16'd500, rd, rsp);
    step(1'b1, 5'h00, 1'b0, 1'b1, 16'h0, rd, rsp);
    rst = 1'b1;
    hsel = 1'b0;
    htrans = 2'b00;
    #1;
    check("midmac_rst_hrdata", hrdata, 0);
    check("midmac_rst_hresp", hresp, 0);
    @(posedge tb_clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (8) step(1'b0, 5'h00, 1'b0, 1'b0, 16'h0, rd, rsp);
    xfer(5'h00, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("midmac_status", rd, 0);
    xfer(5'h02, 1'b0, 1'b1, 16'h0, rd, rsp);
    check("midmac_result", rd, 0);

    // Randomized coefficients, samples and flushes
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int unsigned r = $urandom_range(0, 9);
      if (r < 3) begin
        int          idx = $urandom_range(0, NT - 1);
        logic [15:0] v = 16'($urandom);
        set_coef(idx, v);
        xfer(5'(8 + 2 * idx), 1'b0, 1'b1, 16'h0, rd, rsp);
        check("rand_coef_rb", rd, 16'(mcoef[idx]));
      end else if (r == 3) begin
        xfer(5'h06, 1'b1, 1'b1, 16'h0001, rd, rsp);
        check("rand_flush_resp", rsp, 0);
        for (int i = 0; i < NT; i++) mx[i] = 0;
      end else begin
        run_sample(16'($urandom), res);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_fir_n.md
AHB_LITE_FIR_N -- requirements
Module: ahb_lite_fir_n

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 4, number of filter taps (legal 2..8).
REQ-002 SHALL have parameter ACC_W, default 24, internal accumulator width (at least 20).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port hsel, input, 1 bit: slave select.
REQ-006 SHALL have port haddr, input, 5 bits: byte address.
REQ-007 SHALL have port hsize, input, 1 bit: 0 = byte, 1 = halfword.
REQ-008 SHALL have port htrans, input, 2 bits: 2 = NONSEQ, 3 = SEQ; 0 and 1 are ignored.
REQ-009 SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-010 SHALL have port hwdata, input, 16 bits: write data, valid in data phase.
REQ-011 SHALL have port hrdata, output, 16 bits: read data, valid in data phase.
REQ-012 SHALL have port hresp, output, 1 bit: error response, valid in data phase.

Function
REQ-013 SHALL use this register map:
- 0x00 status (RO): bit0 busy; bit1 overflow (sticky); bit2 new_result.
- 0x02 result (RO).
- 0x04 sample (WO; reads return 0).
- 0x06 control: bit0 written 1 flushes the delay line; reads return 0.
- 0x08+2*i: coefficient i, for i = 0..NUM_TAPS-1, RW.
REQ-014 SHALL latch the address, hwrite and hsize in the address phase when hsel=1 and htrans[1]=1.
REQ-015 SHALL sample hwdata, and apply writes, at the end of the following (data) cycle.
REQ-016 SHALL, for a byte write (hsize=0), update only the lane selected by haddr[0]: 0 = [7:0], 1 = [15:8].
REQ-017 SHALL drive hrdata combinationally from the latched address during the data phase, and 0 otherwise.
REQ-018 SHALL assert hresp for one data-phase cycle, with no register change, on any of:
- write to 0x00–0x03;
- any access at or above 0x08+2*NUM_TAPS;
- write to sample, control or a coefficient while busy.
REQ-019 SHALL treat coefficients as unsigned Q1.15 (0x8000 = 1.0) and samples as unsigned 16-bit.
REQ-020 SHALL have a delay line x[0..NUM_TAPS-1]; an accepted sample write shifts x[i] to x[i+1] and sets x[0] to the new sample.
REQ-021 SHALL implement FSM states IDLE, MAC and DONE:
- IDLE to MAC on the edge that accepts the sample write; at that edge clear the accumulator and tap counter, and clear new_result.
- MAC: each cycle add (x[k]*coef[k])>>15 to the accumulator, k = 0..NUM_TAPS-1; after NUM_TAPS cycles go to DONE.
- DONE (one cycle): result = min(acc, 0xFFFF); if acc > 0xFFFF, set overflow; set new_result; go to IDLE.
REQ-022 SHALL read busy = 1 in MAC and DONE; the result is readable NUM_TAPS+1 cycles after the sample-write edge.
REQ-023 SHALL clear new_result on any result read.
REQ-024 SHALL clear overflow on a status read; if a set event coincides with the read, set wins.
REQ-025 SHALL, on a flush in IDLE, zero the delay line only; coefficients, result and flags are unchanged.
REQ-026 SHALL treat back-to-back pipelined transfers (address phase overlapping the previous data phase) as independent, with no wait states (hready is not modelled).

Reset
REQ-027 SHALL, while rst=1 at a clock edge:
- set the FSM to IDLE;
- clear all coefficients, the delay line, the accumulator, result and flags;
- drop any pending data phase.
REQ-028 SHALL hold hrdata=0 and hresp=0 during and after reset; a reset mid-MAC aborts with no result update.

Verification
REQ-029 SHALL cover reset: rst held 2 cycles, then read status, result and coefficient 0 -> all 0x0000, hresp 0.
REQ-030 SHALL cover NUM_TAPS=4, coefs 0x4000/0x8000/0x8000/0x4000, four samples of 100 each polled to idle -> results 50, 150, 250, 300; busy for exactly 5 cycles per sample.
REQ-031 SHALL cover coefs all 0x8000, samples 0xFFFF then 0xFFFF -> results 0xFFFF then 0xFFFF; overflow=1 after the second; status read clears overflow.
REQ-032 SHALL cover a sample write on the cycle after a sample write (busy) -> hresp=1, delay line unchanged, result matches the single sample.
REQ-033 SHALL cover a byte write 0xAB to 0x09 over coef0=0x1234 -> read 0xAB34; a write to 0x02 -> hresp=1; a read of 0x10 with NUM_TAPS=4 -> hresp=1.
REQ-034 SHALL cover flush in IDLE after three samples, then sample 100 with REQ-030 coefs -> result 50.
